// File: rtl/shift_add_multiplier_if.sv
// Request/result bundle for the shift-add multiply-accumulate unit.
// The requester drives the operands and start; the unit returns busy, done and product.
interface shift_add_multiplier_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [WIDTH-1:0]   addend;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, multiplicand, multiplier, addend,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier, addend,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiply-accumulate: product = multiplicand * multiplier + addend.
// One multiplier bit is retired per clock, followed by a single accumulate cycle.
module shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_add_multiplier_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, ACC} state_e;

  state_e             state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   add_q, add_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   shifted;

  // NOTE: every state register uses <= so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      add_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      add_q     <= add_d;
      count_q   <= count_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  // Partial sum for the current multiplier bit, then shift {A,Q} right by one.
  assign sum     = q_q[0] ? (a_q + {1'b0, m_q}) : a_q;
  assign shifted = {1'b0, sum, q_q[WIDTH-1:1]};

  // NOTE: all next-state signals default to their hold value first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    add_d     = add_q;
    count_d   = count_q;
    product_d = product_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = bus.multiplicand;
          q_d     = bus.multiplier;
          add_d   = bus.addend;
          a_d     = '0;
          count_d = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d     = shifted[2*WIDTH:WIDTH];
        q_d     = shifted[WIDTH-1:0];
        count_d = count_q + 1'b1;
        if (count_q == CNT_W'(WIDTH - 1)) begin
          count_d = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        // Max result (2^W-1)^2 + (2^W-1) fits in 2W bits, so no carry out is kept.
        product_d = {a_q[WIDTH-1:0], q_q} + {{WIDTH{1'b0}}, add_q};
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier (WIDTH=16).
// Expected results are hand-computed constants; latency is counted from the accept edge.
module tb_shift_add_multiplier;
  localparam int WIDTH   = 16;
  localparam int LATENCY = WIDTH + 1;
  localparam int TIMEOUT = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;

  shift_add_multiplier_if #(.WIDTH(WIDTH)) bus ();

  shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands with start for one edge; returns just after the accept edge.
  task automatic start_op(input logic [15:0] m, input logic [15:0] q, input logic [15:0] a);
    bus.multiplicand = m;
    bus.multiplier   = q;
    bus.addend       = a;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start        = 1'b0;
  endtask

  // Count edges until done is seen; optionally hammer the inputs with start while waiting.
  task automatic wait_done(input bit scramble, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!bus.done && scramble) begin
        bus.start        = 1'b1;
        bus.multiplicand = 16'($urandom);
        bus.multiplier   = 16'($urandom);
        bus.addend       = 16'($urandom);
      end
    end while (!bus.done && cyc < TIMEOUT);
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] m, input logic [15:0] q,
                        input logic [15:0] a, input logic [31:0] exp);
    int cyc;
    start_op(m, q, a);
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    wait_done(1'b0, cyc);
    check({tag, "_latency"}, 64'(cyc), 64'(LATENCY));
    check({tag, "_product"}, 64'(bus.product), 64'(exp));
    check({tag, "_busy_in_done"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    check({tag, "_done_low"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int cyc;
    int pulses;
    bus.start        = 1'b1;
    bus.multiplicand = 16'h1234;
    bus.multiplier   = 16'h5678;
    bus.addend       = 16'h9abc;

    // Reset held two cycles with start asserted.
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_product", 64'(bus.product), 64'h0);
    rst       = 1'b0;
    bus.start = 1'b0;
    pulses    = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pulses += int'(bus.done) + int'(bus.busy);
    end
    check("idle_hold", 64'(pulses), 64'd0);

    run_op("basic",   16'd1000, 16'd37,   16'd0,    32'h0000_9088);
    run_op("full",    16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF_0000);
    run_op("zero_m",  16'h0000, 16'h1234, 16'h00AB, 32'h0000_00AB);
    run_op("div_inv", 16'h0003, 16'h0007, 16'h0005, 32'h0000_001A);
    run_op("ffff",    16'h1111, 16'h000F, 16'h0000, 32'h0000_FFFF);

    // Inputs and start change every cycle while busy; the latched operands must win.
    start_op(16'h00C8, 16'h0064, 16'h0007);
    wait_done(1'b1, cyc);
    check("hold_latency", 64'(cyc), 64'(LATENCY));
    check("hold_product", 64'(bus.product), 64'h0000_4E27);

    // Back-to-back: start in the done cycle is accepted.
    start_op(16'h0102, 16'h0304, 16'h0001);
    check("b2b_busy", 64'(bus.busy), 64'd1);
    check("b2b_old_product", 64'(bus.product), 64'h0000_4E27);
    wait_done(1'b0, cyc);
    check("b2b_latency", 64'(cyc), 64'(LATENCY));
    check("b2b_product", 64'(bus.product), 64'h0003_0A09);
    @(negedge clk);

    // Reset during the 8th iteration aborts the operation silently.
    start_op(16'h00FF, 16'h00FF, 16'h0000);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_product", 64'(bus.product), 64'h0);
    check("abort_done", 64'(bus.done), 64'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pulses += int'(bus.done);
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    run_op("post_abort", 16'h0010, 16'h0010, 16'h0000, 32'h0000_0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
